// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared request indices, FSM encoding and helpers for mode_scheduler
package mode_pkg;

  localparam int REQ_INC  = 0;
  localparam int REQ_DEC  = 1;
  localparam int REQ_INC2 = 2;

  localparam int GAP_CYC_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Successor in the circular order inc -> dec -> inc2 -> inc.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    if (oh[REQ_DEC]) begin
      return 2'(REQ_DEC);
    end else if (oh[REQ_INC2]) begin
      return 2'(REQ_INC2);
    end else begin
      return 2'(REQ_INC);
    end
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - three-way round-robin picker, searching from the bit after ptr
module rr_pick3
  import mode_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] pick
);

  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  always_comb begin
    first  = rr_next(ptr);
    second = rr_next(first);
    third  = rr_next(second);
    pick   = '0;
    if (req[first]) begin
      pick[first] = 1'b1;
    end else if (req[second]) begin
      pick[second] = 1'b1;
    end else if (req[third]) begin
      pick[third] = 1'b1;
    end
  end

endmodule

// File: rtl/mode_scheduler.sv
// rtl/mode_scheduler.sv - round-robin burst scheduler driving inc/dec/inc2 of a pulse counter
module mode_scheduler
  import mode_pkg::*;
#(
  parameter int BURST_W = 8,
  parameter int GAP_CYC = GAP_CYC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [15:0]        count_in,
  output logic               inc_o,
  output logic               dec_o,
  output logic               inc2_o,
  output logic [2:0]         grant,
  output logic               busy,
  output logic               done,
  output logic               blocked
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int SUM_W = BURST_W + 18;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [SUM_W-1:0] CNT_MAX  = SUM_W'(17'h0FFFF);

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W:0]   step_q, step_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [2:0]         gnt_q, gnt_d;
  logic               blocked_q, blocked_d;

  logic [2:0]         pick;
  logic [SUM_W-1:0]   cnt_ext;
  logic [SUM_W-1:0]   len_ext;
  logic               refuse;
  logic               pick_ok;
  logic               run_last;
  logic               held;

  rr_pick3 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // Wide enough that count_in + 2*burst_len never wraps.
  assign cnt_ext  = SUM_W'(count_in);
  assign len_ext  = SUM_W'(burst_len);
  assign pick_ok  = (|pick) && (burst_len != '0);
  assign run_last = (step_q == {1'b0, len_q});
  assign held     = |(req & gnt_q);

  always_comb begin
    refuse = 1'b0;
    if (pick[REQ_DEC] && (cnt_ext < len_ext)) begin
      refuse = 1'b1;
    end
    if (pick[REQ_INC] && ((cnt_ext + len_ext) > CNT_MAX)) begin
      refuse = 1'b1;
    end
    if (pick[REQ_INC2] && ((cnt_ext + (len_ext << 1)) > CNT_MAX)) begin
      refuse = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    step_d    = step_q;
    gap_d     = gap_q;
    gnt_d     = gnt_q;
    blocked_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_ok) begin
          ptr_d = onehot_idx(pick);
          if (refuse) begin
            blocked_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            gnt_d   = pick;
            len_d   = burst_len;
            step_d  = '0;
          end
        end
      end
      ST_RUN: begin
        // Step 0 is the counter entry cycle; steps 1..L count.
        if (!held || run_last) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          gap_d   = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'(REQ_INC2);
      len_q     <= '0;
      step_q    <= '0;
      gap_q     <= '0;
      gnt_q     <= '0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      step_q    <= step_d;
      gap_q     <= gap_d;
      gnt_q     <= gnt_d;
      blocked_q <= blocked_d;
    end
  end

  assign inc_o   = gnt_q[REQ_INC];
  assign dec_o   = gnt_q[REQ_DEC];
  assign inc2_o  = gnt_q[REQ_INC2];
  assign grant   = gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_RUN) && run_last;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_mode_scheduler.sv
// tb/tb_mode_scheduler.sv - scoreboard bench for mode_scheduler with a pulse counter model
module tb_mode_scheduler;

  localparam int BW  = 8;
  localparam int GAP = 2;

  typedef struct {
    bit         is_block;
    logic [2:0] grant;
    int         run_len;
    int         done_cnt;
    int         gap_len;
    int         count;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req = 3'b000;
  logic [BW-1:0] burst_len = '0;
  logic [15:0]   count_in;
  logic          inc_o, dec_o, inc2_o;
  logic [2:0]    grant;
  logic          busy, done, blocked;
  logic [2:0]    modes;

  logic          load_en = 1'b0;
  logic [15:0]   load_val = 16'd0;
  logic          expect_idle = 1'b0;
  logic          end_req = 1'b0;
  logic [15:0]   cnt_model = 16'd0;
  logic [2:0]    prev_mode = 3'b000;

  exp_t exp_q[$];
  exp_t e;
  bit   in_burst = 1'b0;
  logic [2:0] b_grant = 3'b000;
  int   b_run = 0, b_done = 0, b_gap = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign modes    = {inc2_o, dec_o, inc_o};
  assign count_in = cnt_model;

  mode_scheduler #(.BURST_W(BW), .GAP_CYC(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .burst_len (burst_len),
    .count_in  (count_in),
    .inc_o     (inc_o),
    .dec_o     (dec_o),
    .inc2_o    (inc2_o),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .blocked   (blocked)
  );

  // External pulse counter: first cycle of a mode is entry, later cycles step.
  always @(posedge clk) begin
    if (load_en) begin
      cnt_model <= load_val;
    end else if (modes != 3'b000 && modes == prev_mode) begin
      if (modes[0]) cnt_model <= cnt_model + 16'd1;
      else if (modes[1]) cnt_model <= cnt_model - 16'd1;
      else cnt_model <= cnt_model + 16'd2;
    end
    prev_mode <= modes;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("mode_onehot", int'($onehot0(modes)), 1);
    check("grant_vs_modes", int'(grant), int'(modes));
    if (expect_idle) check("idle_outputs", int'({modes, grant, busy, done, blocked}), 0);
    if (blocked) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_blocked got blocked=1 expected no event");
      end else begin
        e = exp_q.pop_front();
        check("event_is_block", int'(e.is_block), 1);
        check("blocked_no_drive", int'(modes), 0);
      end
    end
    if (in_burst && !busy) begin
      in_burst = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_burst got grant=%b expected no event", b_grant);
      end else begin
        e = exp_q.pop_front();
        check("event_is_burst", int'(e.is_block), 0);
        check("burst_grant", int'(b_grant), int'(e.grant));
        check("burst_run_len", b_run, e.run_len);
        check("burst_done_cnt", b_done, e.done_cnt);
        check("burst_gap_len", b_gap, e.gap_len);
        check("burst_count", int'(count_in), e.count);
      end
    end
    if (!in_burst && busy) begin
      in_burst = 1'b1;
      b_grant  = grant;
      b_run    = 0;
      b_done   = 0;
      b_gap    = 0;
    end
    if (in_burst) begin
      if (modes != 3'b000) b_run++;
      else b_gap++;
      if (done) b_done++;
    end
    if (end_req) begin
      check("queue_drained", exp_q.size(), 0);
      check("no_open_burst", int'(in_burst), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    load_en  = 1'b1;
    load_val = v;
    tick(1);
    load_en  = 1'b0;
  endtask

  task automatic push_burst(input logic [2:0] g, input int run, input int dn, input int gap, input int cnt);
    exp_t x;
    x.is_block = 1'b0; x.grant = g; x.run_len = run;
    x.done_cnt = dn; x.gap_len = gap; x.count = cnt;
    exp_q.push_back(x);
  endtask

  task automatic push_block();
    exp_t x;
    x.is_block = 1'b1; x.grant = 3'b000; x.run_len = 0;
    x.done_cnt = 0; x.gap_len = 0; x.count = 0;
    exp_q.push_back(x);
  endtask

  task automatic pulse_req(input logic [2:0] r, input int len, input int hold);
    req       = r;
    burst_len = BW'(len);
    tick(hold);
    req       = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    load_en = 1'b1;
    load_val = 16'd0;
    tick(2);
    load_en = 1'b0;
    expect_idle = 1'b1;
    tick(1);
    expect_idle = 1'b0;
    rst = 1'b0;
    tick(2);

    // Single inc burst of 5 from 0.
    push_burst(3'b001, 6, 1, 2, 5);
    pulse_req(3'b001, 5, 7);
    tick(4);

    // All three held: inc, dec, inc2, inc after a fresh reset.
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    push_burst(3'b001, 2, 1, 2, 6);
    push_burst(3'b010, 2, 1, 2, 5);
    push_burst(3'b100, 2, 1, 2, 7);
    push_burst(3'b001, 2, 1, 2, 8);
    pulse_req(3'b111, 1, 18);
    tick(4);

    // Zero-length request is ignored.
    pulse_req(3'b001, 0, 3);
    tick(2);

    // dec below zero is refused.
    load(16'd3);
    push_block();
    pulse_req(3'b010, 4, 1);
    tick(3);

    // inc2 near the top: refused at 3, accepted at 2.
    load(16'hFFFB);
    push_block();
    pulse_req(3'b100, 3, 1);
    tick(3);
    push_burst(3'b100, 3, 1, 2, 16'hFFFF);
    pulse_req(3'b100, 2, 4);
    tick(4);

    // Request dropped on RUN cycle 4.
    load(16'd0);
    push_burst(3'b001, 4, 0, 2, 3);
    pulse_req(3'b001, 10, 4);
    tick(5);

    // Reset on RUN cycle 3, then inc must win over dec.
    push_burst(3'b001, 3, 0, 0, 5);
    req = 3'b001;
    burst_len = BW'(10);
    tick(3);
    rst = 1'b1;
    req = 3'b000;
    tick(1);
    rst = 1'b0;
    expect_idle = 1'b1;
    tick(1);
    expect_idle = 1'b0;
    push_burst(3'b001, 2, 1, 2, 6);
    pulse_req(3'b011, 1, 3);
    tick(5);

    end_req = 1'b1;
    tick(3);
  end

  initial begin
    #50000;
    $display("FAIL watchdog got no end of run expected finish before 50000ns");
    $fatal(1);
  end

endmodule

// File: doc/mode_scheduler.md
MODE_SCHEDULER -- requirements
Module: mode_scheduler

Interface
REQ-001 Parameter BURST_W, default 8, width of the burst-length input.
REQ-002 Parameter GAP_CYC, default 2, number of idle cycles forced between bursts (minimum 1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 req  input  3  level requests; bit0 = inc, bit1 = dec, bit2 = inc2.
REQ-006 burst_len  input  BURST_W  requested count steps per burst; sampled at grant.
REQ-007 count_in  input  16  current counter value from the pulse counter dataout.
REQ-008 inc_o, dec_o, inc2_o  output  1 each  mode drives to the pulse counter; at most one high at any time.
REQ-009 grant  output  3  one-hot copy of the active mode drive; same bit mapping as req.
REQ-010 busy  output  1  high in RUN and GAP.
REQ-011 done  output  1  one-cycle pulse when a burst completes its full length.
REQ-012 blocked  output  1  one-cycle pulse when a request is refused by the range guard.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, GAP.
REQ-014 In IDLE, the block SHALL select one pending req bit by round-robin, searching from the bit after the last granted bit in the order inc, dec, inc2.
REQ-015 The range guard SHALL refuse the selection as follows (17-bit arithmetic, no wrap):
- dec when count_in < burst_len
- inc when count_in + burst_len > 0xFFFF
- inc2 when count_in + 2*burst_len > 0xFFFF
REQ-016 A refused selection SHALL pulse blocked for one cycle, advance the RR pointer past that bit, and stay in IDLE.
REQ-017 A request with burst_len == 0 SHALL be ignored: no grant, no done, no blocked.
REQ-018 An accepted selection SHALL latch burst_len into an internal burst register L, enter RUN on the next edge, and assert the selected mode output from that edge.
REQ-019 In RUN, the mode output SHALL stay high for exactly L+1 consecutive cycles: one counter entry cycle plus L counting cycles.
REQ-020 On the last RUN cycle the block SHALL pulse done for one cycle, then enter GAP with all mode outputs low.
REQ-021 If the granted req bit drops during RUN, the block SHALL deassert the mode output on the next edge and enter GAP without pulsing done.
REQ-022 GAP SHALL last exactly GAP_CYC cycles with all mode outputs low, then return to IDLE.
REQ-023 Requests arriving during RUN or GAP SHALL be held only by their level; there is no queuing.
REQ-024 Simultaneous requests SHALL be resolved by REQ-014, with one grant per burst.
REQ-025 The RUN step counter SHALL be BURST_W+1 bits wide so that L = 2^BURST_W-1 does not wrap.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE and the RR pointer SHALL be set so that inc has highest priority.
REQ-027 On rst, L and all counters SHALL clear, and inc_o, dec_o, inc2_o, grant, busy, done and blocked SHALL be 0 from the next edge.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately, with no done pulse.

Structure
REQ-029 A shared package mode_pkg SHALL hold the req/grant bit indices, the state encoding and the GAP_CYC default.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick3, combinational, with inputs req and pointer and outputs a one-hot pick.

Verification
REQ-031 Bench SHALL cover: req=001, burst_len=5, count_in=0 -> inc_o high 6 cycles, done once, counter reads 5, then 2 GAP cycles.
REQ-032 Bench SHALL cover: req=111 held, burst_len=1 -> grants in order inc, dec, inc2, inc, with GAP_CYC idle cycles between grants.
REQ-033 Bench SHALL cover: req=010, count_in=3, burst_len=4 -> blocked pulses once, dec_o stays 0.
REQ-034 Bench SHALL cover: req=100, count_in=0xFFFB, burst_len=3 -> blocked; with burst_len=2 -> accepted and counter reads 0xFFFF.
REQ-035 Bench SHALL cover: inc burst with burst_len=10, req dropped on RUN cycle 4 -> inc_o low next cycle, no done, GAP entered.
REQ-036 Bench SHALL cover: rst asserted on RUN cycle 3 -> all outputs 0 next edge, FSM in IDLE, next grant goes to inc.
